// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: controller command codes
// and the sequencer state encoding.
package lcd_pkg;

   localparam logic [3:0] WRITE           = 4'd0;
   localparam logic [3:0] SHIFT_UP        = 4'd1;
   localparam logic [3:0] SHIFT_DOWN      = 4'd2;
   localparam logic [3:0] SHIFT_LEFT      = 4'd3;
   localparam logic [3:0] SHIFT_RIGHT     = 4'd4;
   localparam logic [3:0] MAX             = 4'd5;
   localparam logic [3:0] MIN             = 4'd6;
   localparam logic [3:0] AVERAGE         = 4'd7;
   localparam logic [3:0] CTR_CLKWISE_ROT = 4'd8;
   localparam logic [3:0] CLKWISE_ROT     = 4'd9;
   localparam logic [3:0] MIRROR_X        = 4'd10;
   localparam logic [3:0] MIRROR_Y        = 4'd11;
   localparam logic [3:0] FIRST_RESERVED  = 4'd12;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      WAIT_Q,
      WAIT_READY,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      FINISH,
      ERR
   } seq_state_t;

   // Codes 12..15 are used inside the controller and must never be sent to it.
   function automatic logic is_reserved(input logic [3:0] code);
      return code >= FIRST_RESERVED;
   endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
module lcd_seq_timer #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - ONE;
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/lcd_cmd_seq.sv
// Scripted command issuer: fetches 4-bit codes from a command ROM and hands
// them to the LCD controller over its cmd_valid/busy handshake until WRITE completes.
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int ADDR_W       = 5,
   parameter int ACK_TIMEOUT  = 16,
   parameter int DONE_TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              CMD_ROM_rd,
   output logic [ADDR_W-1:0] CMD_ROM_A,
   input  logic [3:0]        CMD_ROM_Q,
   input  logic              busy,
   input  logic              done,
   output logic [3:0]        cmd,
   output logic              cmd_valid,
   output logic              seq_done,
   output logic              error,
   output logic [ADDR_W:0]   issued_cnt,
   output logic [ADDR_W:0]   skip_cnt
);

   localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);

   // The cycle in which an event happens counts toward its window, and the
   // exit decision takes one more edge, so a timeout raises error exactly
   // TIMEOUT cycles after the cmd_valid cycle (ACK) or the ack cycle (DONE).
   localparam logic [TMR_W-1:0]  ACK_LOAD  = TMR_W'(ACK_TIMEOUT - 2);
   localparam logic [TMR_W-1:0]  DONE_LOAD = TMR_W'(DONE_TIMEOUT - 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_MAX   = '1;
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

   seq_state_t        state_reg;
   logic              rom_rd_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [3:0]        cmd_reg;
   logic              cmd_valid_reg;
   logic              seq_done_reg;
   logic              error_reg;
   logic [ADDR_W:0]   issued_reg;
   logic [ADDR_W:0]   skip_reg;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_expired;

   // Timer is held loaded outside the two timed states, so every entry into
   // WAIT_ACK or WAIT_DONE starts from a fresh window.
   assign tmr_load = !(state_reg inside {WAIT_ACK, WAIT_DONE}) ||
                     ((state_reg == WAIT_ACK) && busy);
   assign tmr_val  = (state_reg == WAIT_ACK) ? DONE_LOAD : ACK_LOAD;

   lcd_seq_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         rom_rd_reg    <= 1'b0;
         addr_reg      <= '0;
         cmd_reg       <= '0;
         cmd_valid_reg <= 1'b0;
         seq_done_reg  <= 1'b0;
         error_reg     <= 1'b0;
         issued_reg    <= '0;
         skip_reg      <= '0;
      end else begin
         cmd_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  addr_reg   <= '0;
                  rom_rd_reg <= 1'b1;
                  state_reg  <= FETCH;
               end
            end
            FETCH: begin
               rom_rd_reg <= 1'b0;
               state_reg  <= WAIT_Q;
            end
            WAIT_Q: begin
               cmd_reg <= CMD_ROM_Q;
               if (is_reserved(CMD_ROM_Q)) begin
                  if (skip_reg != CNT_MAX) skip_reg <= skip_reg + CNT_ONE;
                  if (addr_reg == LAST_ADDR) begin
                     error_reg <= 1'b1;
                     state_reg <= ERR;
                  end else begin
                     addr_reg   <= addr_reg + ADDR_ONE;
                     rom_rd_reg <= 1'b1;
                     state_reg  <= FETCH;
                  end
               end else begin
                  state_reg <= WAIT_READY;
               end
            end
            WAIT_READY: begin
               // No timeout here: the controller's power-up image load holds busy.
               if (!busy) begin
                  cmd_valid_reg <= 1'b1;
                  state_reg     <= ISSUE;
               end
            end
            ISSUE: begin
               state_reg <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (busy) begin
                  if (issued_reg != CNT_MAX) issued_reg <= issued_reg + CNT_ONE;
                  if (cmd_reg == WRITE) begin
                     state_reg <= WAIT_DONE;
                  end else if (addr_reg == LAST_ADDR) begin
                     error_reg <= 1'b1;
                     state_reg <= ERR;
                  end else begin
                     addr_reg   <= addr_reg + ADDR_ONE;
                     rom_rd_reg <= 1'b1;
                     state_reg  <= FETCH;
                  end
               end else if (tmr_expired) begin
                  error_reg <= 1'b1;
                  state_reg <= ERR;
               end
            end
            WAIT_DONE: begin
               if (done) begin
                  seq_done_reg <= 1'b1;
                  state_reg    <= FINISH;
               end else if (tmr_expired) begin
                  error_reg <= 1'b1;
                  state_reg <= ERR;
               end
            end
            FINISH: begin
               rom_rd_reg <= 1'b0;
            end
            ERR: begin
               rom_rd_reg <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign CMD_ROM_rd = rom_rd_reg;
   assign CMD_ROM_A  = addr_reg;
   assign cmd        = cmd_reg;
   assign cmd_valid  = cmd_valid_reg;
   assign seq_done   = seq_done_reg;
   assign error      = error_reg;
   assign issued_cnt = issued_reg;
   assign skip_cnt   = skip_reg;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: two instances (ADDR_W=5 and ADDR_W=2) driven by
// behavioural command ROMs and LCD controller models, with a cmd scoreboard.
module tb_lcd_cmd_seq;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;

   always #5 clk = ~clk;

   // per-instance handshake signals, index 0 = ADDR_W 5, index 1 = ADDR_W 2
   logic       busy_w      [2];
   logic       done_w      [2];
   logic [3:0] cmd_w       [2];
   logic       cmd_valid_w [2];

   logic       rd0, rd1;
   logic [4:0] a0;
   logic [1:0] a1;
   logic [3:0] q0, q1;
   logic       seq_done0, seq_done1, error0, error1;
   logic [5:0] issued0, skip0;
   logic [2:0] issued1, skip1;

   logic [3:0] rom0 [32];
   logic [3:0] rom1 [4];

   int asserts  = 0;
   int failures = 0;
   int cyc      = 0;

   logic [3:0] exp_q0 [$];
   logic [3:0] exp_q1 [$];

   lcd_cmd_seq #(.ADDR_W(5), .ACK_TIMEOUT(16), .DONE_TIMEOUT(256)) dut0 (
      .clk(clk), .reset(reset), .start(start0),
      .CMD_ROM_rd(rd0), .CMD_ROM_A(a0), .CMD_ROM_Q(q0),
      .busy(busy_w[0]), .done(done_w[0]),
      .cmd(cmd_w[0]), .cmd_valid(cmd_valid_w[0]),
      .seq_done(seq_done0), .error(error0),
      .issued_cnt(issued0), .skip_cnt(skip0)
   );

   lcd_cmd_seq #(.ADDR_W(2), .ACK_TIMEOUT(16), .DONE_TIMEOUT(256)) dut1 (
      .clk(clk), .reset(reset), .start(start1),
      .CMD_ROM_rd(rd1), .CMD_ROM_A(a1), .CMD_ROM_Q(q1),
      .busy(busy_w[1]), .done(done_w[1]),
      .cmd(cmd_w[1]), .cmd_valid(cmd_valid_w[1]),
      .seq_done(seq_done1), .error(error1),
      .issued_cnt(issued1), .skip_cnt(skip1)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rd0) q0 <= rom0[a0];
      if (rd1) q1 <= rom1[a1];
   end

   // Controller model: busy for 65 cycles after reset, then each accepted
   // command holds busy for op_len cycles; WRITE raises a sticky done after.
   int  load_cnt [2];
   int  op_cnt   [2];
   int  op_len   [2];
   bit  pend_wr  [2];
   bit  ack_en   [2];
   bit  done_en  [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            busy_w[i]   <= 1'b1;
            done_w[i]   <= 1'b0;
            load_cnt[i] <= 65;
            op_cnt[i]   <= 0;
            pend_wr[i]  <= 1'b0;
         end else if (load_cnt[i] != 0) begin
            load_cnt[i] <= load_cnt[i] - 1;
            if (load_cnt[i] == 1) busy_w[i] <= 1'b0;
         end else if (cmd_valid_w[i] && ack_en[i]) begin
            busy_w[i]  <= 1'b1;
            op_cnt[i]  <= op_len[i];
            pend_wr[i] <= (cmd_w[i] == 4'd0);
         end else if (busy_w[i]) begin
            op_cnt[i] <= op_cnt[i] - 1;
            if (op_cnt[i] <= 1) begin
               busy_w[i] <= 1'b0;
               if (pend_wr[i] && done_en[i]) done_w[i] <= 1'b1;
            end
         end
      end
   end

   // Scoreboard: every cmd_valid pops the next expected code.
   bit         prev_valid [2] = '{1'b0, 1'b0};
   bit         mon_have;
   logic [3:0] mon_exp;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (cmd_valid_w[i]) begin
            mon_have = 1'b0;
            mon_exp  = 4'd0;
            if (i == 0 && exp_q0.size() > 0) begin
               mon_have = 1'b1;
               mon_exp  = exp_q0.pop_front();
            end else if (i == 1 && exp_q1.size() > 0) begin
               mon_have = 1'b1;
               mon_exp  = exp_q1.pop_front();
            end
            $display("txn dut%0d t=%0d cmd=%0d expected=%0d", i, cyc, cmd_w[i], mon_exp);
            asserts++;
            if (!mon_have) begin
               failures++;
               $display("FAIL unexpected_cmd dut%0d: got cmd %0d, required no cmd_valid", i, cmd_w[i]);
            end else if (cmd_w[i] !== mon_exp) begin
               failures++;
               $display("FAIL cmd_order dut%0d: got %0d, required %0d", i, cmd_w[i], mon_exp);
            end
            asserts++;
            if (busy_w[i] !== 1'b0) begin
               failures++;
               $display("FAIL valid_while_busy dut%0d: busy %b, required 0", i, busy_w[i]);
            end
            asserts++;
            if (prev_valid[i]) begin
               failures++;
               $display("FAIL valid_back_to_back dut%0d: previous cycle valid 1, required 0", i);
            end
         end
         prev_valid[i] = cmd_valid_w[i];
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start0();
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic load_rom0(input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] c3);
      for (int i = 0; i < 32; i++) rom0[i] = 4'hF;
      rom0[0] = c0;
      rom0[1] = c1;
      rom0[2] = c2;
      rom0[3] = c3;
   endtask

   task automatic wait_end0(input int budget);
      int n;
      n = 0;
      while (!(seq_done0 || error0) && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      asserts++;
      if ({rd0, cmd_valid_w[0], seq_done0, error0} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b, required 0000", {rd0, cmd_valid_w[0], seq_done0, error0});
      end
      asserts++;
      if ({a0, cmd_w[0]} !== 9'd0) begin
         failures++;
         $display("FAIL reset_addr_cmd: got A=%0d cmd=%0d, required 0 0", a0, cmd_w[0]);
      end
      asserts++;
      if ({issued0, skip0} !== 12'd0) begin
         failures++;
         $display("FAIL reset_counters: got issued=%0d skip=%0d, required 0 0", issued0, skip0);
      end
      asserts++;
      if ({rd1, a1, cmd_w[1], cmd_valid_w[1], seq_done1, error1, issued1, skip1} !== 16'd0) begin
         failures++;
         $display("FAIL reset_dut1: got nonzero outputs, required all 0");
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      load_rom0(4'd3, 4'd9, 4'd7, 4'd0);
      exp_q0.delete();
      exp_q0.push_back(4'd3); exp_q0.push_back(4'd9);
      exp_q0.push_back(4'd7); exp_q0.push_back(4'd0);
      do_reset();
      pulse_start0();
      wait_end0(400);
      asserts++;
      if (seq_done0 !== 1'b1) begin
         failures++;
         $display("FAIL basic_seq_done: got %b, required 1", seq_done0);
      end
      asserts++;
      if (error0 !== 1'b0) begin
         failures++;
         $display("FAIL basic_error: got %b, required 0", error0);
      end
      asserts++;
      if (issued0 !== 6'd4) begin
         failures++;
         $display("FAIL basic_issued: got %0d, required 4", issued0);
      end
      asserts++;
      if (exp_q0.size() != 0) begin
         failures++;
         $display("FAIL basic_pending: got %0d unissued, required 0", exp_q0.size());
      end
   endtask

   task automatic test_skip_illegal();
      load_rom0(4'd13, 4'd5, 4'd0, 4'hF);
      exp_q0.delete();
      exp_q0.push_back(4'd5); exp_q0.push_back(4'd0);
      do_reset();
      pulse_start0();
      wait_end0(400);
      asserts++;
      if (skip0 !== 6'd1) begin
         failures++;
         $display("FAIL skip_count: got %0d, required 1", skip0);
      end
      asserts++;
      if (issued0 !== 6'd2) begin
         failures++;
         $display("FAIL skip_issued: got %0d, required 2", issued0);
      end
      asserts++;
      if ({seq_done0, error0} !== 2'b10) begin
         failures++;
         $display("FAIL skip_status: got done/err %b, required 10", {seq_done0, error0});
      end
      asserts++;
      if (exp_q0.size() != 0) begin
         failures++;
         $display("FAIL skip_pending: got %0d unissued, required 0", exp_q0.size());
      end
   endtask

   task automatic test_ack_timeout();
      int n, t0, t1;
      load_rom0(4'd3, 4'd9, 4'd7, 4'd0);
      exp_q0.delete();
      exp_q0.push_back(4'd3);
      ack_en[0] = 1'b0;
      do_reset();
      pulse_start0();
      n = 0;
      while (!cmd_valid_w[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      t0 = cyc;
      n = 0;
      while (!error0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      asserts++;
      if (t1 - t0 != 16) begin
         failures++;
         $display("FAIL ack_timeout_latency: got %0d cycles, required 16", t1 - t0);
      end
      repeat (20) @(negedge clk);
      asserts++;
      if ({seq_done0, error0} !== 2'b01) begin
         failures++;
         $display("FAIL ack_timeout_status: got done/err %b, required 01", {seq_done0, error0});
      end
      asserts++;
      if (issued0 !== 6'd0) begin
         failures++;
         $display("FAIL ack_timeout_issued: got %0d, required 0", issued0);
      end
      ack_en[0] = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n;
      load_rom0(4'd3, 4'd9, 4'd7, 4'd0);
      exp_q0.delete();
      exp_q0.push_back(4'd3); exp_q0.push_back(4'd9);
      do_reset();
      pulse_start0();
      n = 0;
      while (!(cmd_valid_w[0] && cmd_w[0] == 4'd9) && n < 300) begin
         @(negedge clk);
         n++;
      end
      ack_en[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      asserts++;
      if ({rd0, cmd_valid_w[0], seq_done0, error0, a0, cmd_w[0]} !== 13'd0) begin
         failures++;
         $display("FAIL midreset_outputs: got A=%0d cmd=%0d flags=%b, required all 0",
                  a0, cmd_w[0], {rd0, cmd_valid_w[0], seq_done0, error0});
      end
      asserts++;
      if (issued0 !== 6'd0) begin
         failures++;
         $display("FAIL midreset_issued: got %0d, required 0", issued0);
      end
      ack_en[0] = 1'b1;
      repeat (100) @(negedge clk);
      asserts++;
      if ({rd0, seq_done0, error0} !== 3'b000) begin
         failures++;
         $display("FAIL midreset_idle: got rd/done/err %b, required 000", {rd0, seq_done0, error0});
      end
      exp_q0.delete();
      exp_q0.push_back(4'd3); exp_q0.push_back(4'd9);
      exp_q0.push_back(4'd7); exp_q0.push_back(4'd0);
      pulse_start0();
      wait_end0(400);
      asserts++;
      if ({seq_done0, error0, issued0} !== {2'b10, 6'd4}) begin
         failures++;
         $display("FAIL midreset_replay: got done=%b err=%b issued=%0d, required 1 0 4",
                  seq_done0, error0, issued0);
      end
   endtask

   task automatic test_done_timeout();
      int n, tw, te;
      load_rom0(4'd3, 4'd0, 4'hF, 4'hF);
      exp_q0.delete();
      exp_q0.push_back(4'd3); exp_q0.push_back(4'd0);
      op_len[0]  = 5;
      done_en[0] = 1'b0;
      do_reset();
      pulse_start0();
      n = 0;
      while (!cmd_valid_w[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      // four cycles after cmd_valid the sequencer is parked in WAIT_READY
      repeat (4) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      n = 0;
      while (!(cmd_valid_w[0] && cmd_w[0] == 4'd0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      tw = cyc;
      n = 0;
      while (!error0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      te = cyc;
      asserts++;
      if (te - tw != 257) begin
         failures++;
         $display("FAIL done_timeout_latency: got %0d cycles after WRITE valid, required 257", te - tw);
      end
      asserts++;
      if ({seq_done0, error0, issued0} !== {2'b01, 6'd2}) begin
         failures++;
         $display("FAIL done_timeout_status: got done=%b err=%b issued=%0d, required 0 1 2",
                  seq_done0, error0, issued0);
      end
      asserts++;
      if (exp_q0.size() != 0) begin
         failures++;
         $display("FAIL done_timeout_pending: got %0d unissued, required 0", exp_q0.size());
      end
      op_len[0]  = 1;
      done_en[0] = 1'b1;
   endtask

   task automatic test_overrun();
      int n;
      rom1[0] = 4'd1; rom1[1] = 4'd2; rom1[2] = 4'd3; rom1[3] = 4'd4;
      exp_q1.delete();
      exp_q1.push_back(4'd1); exp_q1.push_back(4'd2);
      exp_q1.push_back(4'd3); exp_q1.push_back(4'd4);
      do_reset();
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!(seq_done1 || error1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      asserts++;
      if ({seq_done1, error1} !== 2'b01) begin
         failures++;
         $display("FAIL overrun_status: got done/err %b, required 01", {seq_done1, error1});
      end
      asserts++;
      if (issued1 !== 3'd4) begin
         failures++;
         $display("FAIL overrun_issued: got %0d, required 4", issued1);
      end
      asserts++;
      if (exp_q1.size() != 0) begin
         failures++;
         $display("FAIL overrun_pending: got %0d unissued, required 0", exp_q1.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         ack_en[i]  = 1'b1;
         done_en[i] = 1'b1;
         op_len[i]  = 1;
      end
      for (int i = 0; i < 32; i++) rom0[i] = 4'hF;
      for (int i = 0; i < 4; i++) rom1[i] = 4'hF;
      test_reset();
      test_basic();
      test_skip_illegal();
      test_ack_timeout();
      test_reset_mid();
      test_done_timeout();
      test_overrun();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Scripted command issuer that sits directly upstream of the LCD controller and drives its cmd/cmd_valid inputs.
- Reads 4-bit command codes from a small command ROM and issues each one using the controller's busy handshake.
- Stops after the WRITE command (code 0) once the controller reports done.
- Used in system bring-up and as the standalone stimulus source for the image-processing datapath.

Parameters:
ADDR_W, 5, command ROM address width (script depth 2**ADDR_W)
ACK_TIMEOUT, 16, max cycles from cmd_valid to busy=1 before error
DONE_TIMEOUT, 256, max cycles from WRITE acceptance to done=1 before error

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begins script from address 0
CMD_ROM_rd  out  1  command ROM read enable
CMD_ROM_A  out  ADDR_W  command ROM address
CMD_ROM_Q  in  4  ROM data, valid the cycle after CMD_ROM_rd/CMD_ROM_A
busy  in  1  controller busy
done  in  1  controller done
cmd  out  4  command to controller
cmd_valid  out  1  command strobe, one cycle
seq_done  out  1  sticky: script finished cleanly
error  out  1  sticky: timeout or script overrun
issued_cnt  out  ADDR_W+1  commands issued
skip_cnt  out  ADDR_W+1  illegal codes skipped

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, port names clk and reset.
- Reset values: all outputs 0 (CMD_ROM_rd, CMD_ROM_A, cmd, cmd_valid, seq_done, error, both counters); state IDLE.
- Reset mid-operation: takes effect at the next edge from any state; a new start is required afterwards.
- States: IDLE, FETCH, WAIT_Q, WAIT_READY, ISSUE, WAIT_ACK, WAIT_DONE, FINISH, ERR.
- IDLE: on start=1 go to FETCH with CMD_ROM_A=0.
- FETCH: CMD_ROM_rd=1 for one cycle, then go to WAIT_Q.
- WAIT_Q: latch CMD_ROM_Q into cmd.
  - If the code is 12..15, it is illegal (reserved as controller-internal). Do not issue it; skip_cnt+1 and advance the address.
    - If the address was not the last, go back to FETCH.
    - If it was the last (2**ADDR_W-1), go to ERR.
  - Otherwise go to WAIT_READY.
- WAIT_READY: wait, with no timeout, until busy=0 is sampled; this covers the controller's 65-cycle image load after reset. Then go to ISSUE.
- ISSUE: cmd_valid=1 for exactly one cycle with cmd stable, then go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK: wait for busy=1.
  - If the counter reaches ACK_TIMEOUT first, go to ERR.
  - On busy=1, issued_cnt+1, then:
    - if cmd==0, go to WAIT_DONE;
    - else if the address is the last, go to ERR (script overrun, no WRITE);
    - else increment the address and go to FETCH.
  - The next command is never issued until busy has dropped again (enforced via WAIT_READY).
- WAIT_DONE: on done=1 go to FINISH. If DONE_TIMEOUT cycles pass first, go to ERR.
- FINISH: seq_done=1 and CMD_ROM_rd=0; stay until reset. start is ignored.
- ERR: error=1, cmd_valid=0; stay until reset. start is ignored.
- start outside IDLE is ignored.
- busy=1 and done=1 in the same cycle in WAIT_ACK: the ack is taken; done is re-evaluated in WAIT_DONE on the next cycle.
- cmd_valid is never asserted while busy=1 is sampled, and never in two consecutive cycles.
- Counters saturate at all-ones and do not wrap.
- The timeout counter is $clog2(DONE_TIMEOUT+1) bits and is cleared on every state entry.

Decomposition:
- Package lcd_pkg holds the command code constants: WRITE=0, SHIFT_UP=1, SHIFT_DOWN=2, SHIFT_LEFT=3, SHIFT_RIGHT=4, MAX=5, MIN=6, AVERAGE=7, CTR_CLKWISE_ROT=8, CLKWISE_ROT=9, MIRROR_X=10, MIRROR_Y=11, and FIRST_RESERVED=12.
- lcd_pkg also holds the sequencer state enum.
- One sub-module is natural: lcd_seq_timer, a loadable, clearable saturating down-counter with an expire flag, shared by the ACK and DONE timeouts.

Test Plan:
- Script [3,9,7,0] with a behavioural controller (busy high during 65-cycle load, 1-cycle ops) -> cmd_valid pulses carry 3,9,7,0, each only after busy=0; after done, seq_done=1, issued_cnt=4, error=0.
- Script [13,5,0] -> code 13 never appears with cmd_valid; skip_cnt=1; cmd 5 then 0 issued; seq_done=1.
- Controller never raises busy after the first cmd_valid -> error=1 exactly 16 cycles after ISSUE; no further cmd_valid; seq_done=0.
- ADDR_W=2, script [1,2,3,4] with no WRITE -> four commands issued, then error=1 and issued_cnt=4.
- Reset asserted in WAIT_ACK -> next cycle all outputs 0 and state IDLE; a second start replays from address 0.
- start pulsed again during WAIT_READY, and done held 0 after WRITE -> extra start ignored; error=1 at 256 cycles after the WRITE ack.
